// File: rtl/wb_mux_n.sv
// wb_mux_n: Wishbone 1-to-N mux decoding adr[SEL_LSB +: SEL_W]; unmapped indices answer 32'hDEAD_BEEF.
// Latency: stb_p rises the cycle after the request is sampled, ack the cycle after ack_p is sampled (min 3).
// Backpressure: one transaction in flight; requests are only taken in IDLE. Ack timeout: define WB_MUX_N_TIMEOUT_EN.
module wb_mux_n #(
  parameter int NUM_PERIPH     = 4,
  parameter int SEL_LSB        = 24,
  parameter int SEL_W          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       io_wbs_clk,
  input  logic                       io_wbs_rst_n,
  // master side
  input  logic [31:0]                io_wbs_adr,
  input  logic [31:0]                io_wbs_datwr,
  input  logic [3:0]                 io_wbs_sel,
  input  logic                       io_wbs_we,
  input  logic                       io_wbs_stb,
  input  logic                       io_wbs_cyc,
  output logic [31:0]                io_wbs_datrd,
  output logic                       io_wbs_ack,
  // peripheral side, port k in slice k
  output logic [32*NUM_PERIPH-1:0]   io_wbs_adr_p,
  output logic [32*NUM_PERIPH-1:0]   io_wbs_datwr_p,
  output logic [4*NUM_PERIPH-1:0]    io_wbs_sel_p,
  output logic [NUM_PERIPH-1:0]      io_wbs_we_p,
  output logic [NUM_PERIPH-1:0]      io_wbs_stb_p,
  output logic [NUM_PERIPH-1:0]      io_wbs_cyc_p,
  input  logic [32*NUM_PERIPH-1:0]   io_wbs_datrd_p,
  input  logic [NUM_PERIPH-1:0]      io_wbs_ack_p,
  output logic                       io_timeout_o
);

  localparam logic [31:0] UNMAPPED_DAT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                 state_q;
  logic [SEL_W-1:0]       idx_q;
  logic [31:0]            adr_q;
  logic [31:0]            datwr_q;
  logic [3:0]             sel_q;
  logic                   we_q;
  logic [31:0]            datrd_q;
  logic                   ack_q;
  logic [NUM_PERIPH-1:0]  stb_q;

  logic [SEL_W-1:0]       req_idx;
  logic [NUM_PERIPH-1:0]  req_onehot;
  logic                   tgt_ack;
  logic [31:0]            tgt_dat;
  logic                   timeout_hit;

  assign req_idx = io_wbs_adr[SEL_LSB+SEL_W-1:SEL_LSB];

  // Decode the incoming index to a one-hot strobe (all-zero when unmapped) and select the active port's ack/data.
  always_comb begin
    req_onehot = '0;
    tgt_ack    = 1'b0;
    tgt_dat    = '0;
    for (int k = 0; k < NUM_PERIPH; k++) begin
      req_onehot[k] = (req_idx == SEL_W'(k));
      if (idx_q == SEL_W'(k)) begin
        tgt_ack = io_wbs_ack_p[k];
        tgt_dat = io_wbs_datrd_p[k*32 +: 32];
      end
    end
  end

  // Transaction FSM; abort beats ack, and ack beats timeout on the same edge.
  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      adr_q   <= '0;
      datwr_q <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      datrd_q <= '0;
      ack_q   <= 1'b0;
      stb_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          if (io_wbs_cyc && io_wbs_stb) begin
            idx_q   <= req_idx;
            adr_q   <= io_wbs_adr;
            datwr_q <= io_wbs_datwr;
            sel_q   <= io_wbs_sel;
            we_q    <= io_wbs_we;
            if (|req_onehot) begin
              stb_q   <= req_onehot;
              state_q <= ACTIVE;
            end else begin
              datrd_q <= UNMAPPED_DAT;
              ack_q   <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        ACTIVE: begin
          if (!io_wbs_cyc) begin
            stb_q   <= '0;
            state_q <= IDLE;
          end else if (tgt_ack) begin
            datrd_q <= tgt_dat;
            stb_q   <= '0;
            ack_q   <= 1'b1;
            state_q <= RESP;
          end else if (timeout_hit) begin
            datrd_q <= UNMAPPED_DAT;
            stb_q   <= '0;
            ack_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          stb_q   <= '0;
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef WB_MUX_N_TIMEOUT_EN
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  assign timeout_hit  = (cnt_q == CNT_LAST);
  assign io_timeout_o = timeout_q;

  // Count ACTIVE cycles; the counter sits at 0 outside ACTIVE so every new transaction starts fresh.
  always_ff @(posedge io_wbs_clk or negedge io_wbs_rst_n) begin
    if (!io_wbs_rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state_q == ACTIVE) && io_wbs_cyc && !tgt_ack && timeout_hit;
      if (state_q == ACTIVE) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end
`else
  // Without the timeout the mux waits forever; the parameter is kept so instantiations stay portable.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout_hit        = 1'b0;
  assign io_timeout_o       = 1'b0;
`endif

  // Request fields go to every port; only stb/cyc select the target.
  assign io_wbs_adr_p   = {NUM_PERIPH{adr_q}};
  assign io_wbs_datwr_p = {NUM_PERIPH{datwr_q}};
  assign io_wbs_sel_p   = {NUM_PERIPH{sel_q}};
  assign io_wbs_we_p    = {NUM_PERIPH{we_q}};
  assign io_wbs_stb_p   = stb_q;
  assign io_wbs_cyc_p   = stb_q;
  assign io_wbs_datrd   = datrd_q;
  assign io_wbs_ack     = ack_q;

endmodule
